// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits MSB-first, even parity, stop=0.
// Presents good words on a valid/ready port and flags parity, framing and overrun errors.
module sipo_frame_rx #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [WIDTH-1:0] dout_data,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             parity_err,
  output logic             framing_err,
  output logic             overrun,
  output logic [CNT_W-1:0] frame_count
);

  localparam int unsigned BCW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BCW-1:0]   BC_ONE   = BCW'(1);
  localparam logic [BCW-1:0]   BC_LAST  = BCW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state_q;
  logic [BCW-1:0]   bit_cnt_q;
  logic [WIDTH-1:0] sh_q;
  logic             par_ok_q;
  logic [WIDTH-1:0] dout_data_q;
  logic             dout_valid_q;
  logic             parity_err_q;
  logic             framing_err_q;
  logic             overrun_q;
  logic [CNT_W-1:0] frame_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      sh_q          <= '0;
      par_ok_q      <= 1'b0;
      dout_data_q   <= '0;
      dout_valid_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
      // A consume clears valid; a load in STOP on the same edge overrides this below.
      if (dout_valid_q && dout_ready) dout_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (din) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          sh_q      <= {sh_q[WIDTH-2:0], din};
          bit_cnt_q <= bit_cnt_q + BC_ONE;
          if (bit_cnt_q == BC_LAST) state_q <= PARITY;
        end
        PARITY: begin
          par_ok_q <= ~(^sh_q ^ din);
          state_q  <= STOP;
        end
        STOP: begin
          state_q <= IDLE;
          if (din) begin
            framing_err_q <= 1'b1;
          end else if (!par_ok_q) begin
            parity_err_q <= 1'b1;
          end else if (!dout_valid_q || dout_ready) begin
            dout_data_q   <= sh_q;
            dout_valid_q  <= 1'b1;
            frame_count_q <= frame_count_q + CNT_ONE;
          end else begin
            overrun_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout_data   = dout_data_q;
  assign dout_valid  = dout_valid_q;
  assign parity_err  = parity_err_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench for sipo_frame_rx: expected words queued as frames are driven,
// popped by a monitor at each handshake; flags and counter checked inline.
module tb_sipo_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       dout_ready = 1'b1;
  logic [3:0] dout_data;
  logic       dout_valid;
  logic       parity_err;
  logic       framing_err;
  logic       overrun;
  logic [7:0] frame_count;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb[$];
  logic [7:0] exp_fc;

  sipo_frame_rx #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .din(din),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .parity_err(parity_err), .framing_err(framing_err), .overrun(overrun),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake completes at the next rising edge; sample on the falling edge.
  always @(negedge clk) begin
    if (!rst && dout_valid === 1'b1 && dout_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_word", {28'd0, dout_data}, 32'hFFFF_FFFF);
      end else begin
        check("sb_word", {28'd0, dout_data}, {28'd0, sb.pop_front()});
      end
    end
  end

  task automatic bit_step(input logic b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_head(input logic [3:0] d, input logic p);
    bit_step(1'b1);
    for (int i = 3; i >= 0; i--) bit_step(d[i]);
    bit_step(p);
  endtask

  task automatic send_frame(input logic [3:0] d, input logic p, input logic stop);
    send_head(d, p);
    bit_step(stop);
  endtask

  task automatic check_flags(input string tag, input logic pe, input logic fe, input logic ov);
    check({tag, "_perr"}, {31'd0, parity_err}, {31'd0, pe});
    check({tag, "_ferr"}, {31'd0, framing_err}, {31'd0, fe});
    check({tag, "_ovr"}, {31'd0, overrun}, {31'd0, ov});
  endtask

  initial begin
    logic [3:0] d;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_data", {28'd0, dout_data}, 32'd0);
    check("rst_fc", {24'd0, frame_count}, 32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    bit_step(1'b0);
    exp_fc = 8'd0;

    // Good frame 1011, P=1
    sb.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 1'b0);
    exp_fc++;
    check("good_valid", {31'd0, dout_valid}, 32'd1);
    check("good_data", {28'd0, dout_data}, 32'hB);
    check("good_fc", {24'd0, frame_count}, {24'd0, exp_fc});
    check_flags("good", 1'b0, 1'b0, 1'b0);
    bit_step(1'b0);
    check("good_valid_clr", {31'd0, dout_valid}, 32'd0);

    // Parity error: 1011 with P=0
    send_frame(4'b1011, 1'b0, 1'b0);
    check_flags("par", 1'b1, 1'b0, 1'b0);
    check("par_valid", {31'd0, dout_valid}, 32'd0);
    check("par_fc", {24'd0, frame_count}, {24'd0, exp_fc});
    bit_step(1'b0);
    check("par_pulse_end", {31'd0, parity_err}, 32'd0);

    // Framing error (parity also bad, framing wins), then immediate good frame
    send_frame(4'b0110, 1'b1, 1'b1);
    check_flags("frm", 1'b0, 1'b1, 1'b0);
    check("frm_valid", {31'd0, dout_valid}, 32'd0);
    sb.push_back(4'b0011);
    send_frame(4'b0011, 1'b0, 1'b0);
    exp_fc++;
    check("frm_next_data", {28'd0, dout_data}, 32'h3);
    check("frm_next_valid", {31'd0, dout_valid}, 32'd1);
    check("frm_next_fc", {24'd0, frame_count}, {24'd0, exp_fc});
    check_flags("frm_next", 1'b0, 1'b0, 1'b0);
    bit_step(1'b0);

    // Overrun: consumer stalled, two frames back-to-back
    dout_ready = 1'b0;
    sb.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 1'b0);
    exp_fc++;
    send_frame(4'b0110, 1'b0, 1'b0);
    check_flags("ovr", 1'b0, 1'b0, 1'b1);
    check("ovr_data", {28'd0, dout_data}, 32'hB);
    check("ovr_valid", {31'd0, dout_valid}, 32'd1);
    check("ovr_fc", {24'd0, frame_count}, {24'd0, exp_fc});
    dout_ready = 1'b1;
    bit_step(1'b0);
    check("ovr_valid_clr", {31'd0, dout_valid}, 32'd0);
    check("ovr_pulse_end", {31'd0, overrun}, 32'd0);

    // Consume and load on the same edge
    dout_ready = 1'b0;
    sb.push_back(4'b1011);
    send_frame(4'b1011, 1'b1, 1'b0);
    exp_fc++;
    sb.push_back(4'b0110);
    send_head(4'b0110, 1'b0);
    dout_ready = 1'b1;
    bit_step(1'b0);
    exp_fc++;
    check("cl_valid", {31'd0, dout_valid}, 32'd1);
    check("cl_data", {28'd0, dout_data}, 32'h6);
    check("cl_fc", {24'd0, frame_count}, {24'd0, exp_fc});
    check_flags("cl", 1'b0, 1'b0, 1'b0);
    bit_step(1'b0);
    check("cl_valid_clr", {31'd0, dout_valid}, 32'd0);

    // Reset mid-frame with a pending word that is lost
    dout_ready = 1'b0;
    sb.push_back(4'b0101);
    send_frame(4'b0101, 1'b0, 1'b0);
    check("pend_valid", {31'd0, dout_valid}, 32'd1);
    bit_step(1'b1);
    bit_step(1'b1);
    bit_step(1'b0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_fc = 8'd0;
    check("mrst_valid", {31'd0, dout_valid}, 32'd0);
    check("mrst_data", {28'd0, dout_data}, 32'd0);
    check("mrst_fc", {24'd0, frame_count}, 32'd0);
    check_flags("mrst", 1'b0, 1'b0, 1'b0);
    dout_ready = 1'b1;
    sb.push_back(4'b1111);
    send_frame(4'b1111, 1'b0, 1'b0);
    exp_fc++;
    check("mrst_next_data", {28'd0, dout_data}, 32'hF);
    check("mrst_next_fc", {24'd0, frame_count}, {24'd0, exp_fc});

    // Back-to-back random good frames to wrap the counter past 255
    for (int n = 0; n < 255; n++) begin
      d = 4'($urandom_range(0, 15));
      sb.push_back(d);
      send_frame(d, ^d, 1'b0);
      exp_fc++;
      if (n % 32 == 0) begin
        check("rnd_data", {28'd0, dout_data}, {28'd0, d});
        check("rnd_fc", {24'd0, frame_count}, {24'd0, exp_fc});
      end
    end
    check("wrap_fc", {24'd0, frame_count}, 32'd0);
    bit_step(1'b0);
    bit_step(1'b0);
    check("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_frame_rx.md
# sipo_frame_rx

Serial-to-parallel frame receiver that sits directly downstream of the serial shift-register stage and consumes its one-bit-per-clock output stream. It detects a start bit, shifts in WIDTH data bits MSB-first, checks even parity and the stop bit, then presents the word on a valid/ready parallel port. It also reports parity, framing and overrun errors and counts good frames. The serial line idles low, and each bit occupies exactly one clk cycle; there is no oversampling.

## Interface
- WIDTH, 4: data bits per frame (≥2).
- CNT_W, 8: width of the good-frame counter.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  1  serial input bit, sampled every rising edge.
- dout_data  out  WIDTH  received word, held stable while dout_valid=1.
- dout_valid  out  1  word available.
- dout_ready  in  1  consumer accepts the word when dout_valid=1 at a rising edge.
- parity_err  out  1  one-cycle pulse: frame had a bad parity bit.
- framing_err  out  1  one-cycle pulse: frame had a bad stop bit (din=1).
- overrun  out  1  one-cycle pulse: a good frame was dropped because the output was full.
- frame_count  out  CNT_W  number of good frames accepted into the output register; wraps modulo 2^CNT_W.

## Operation
- Frame format, one bit per clock: start=1, D[WIDTH-1] … D[0] (MSB first), P, stop=0.
- P is the even-parity bit: the XOR of D and P must equal 0.
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: if din=1, go to DATA and clear bit_cnt. Otherwise stay in IDLE.
- DATA: update shift register as sh <= {sh[WIDTH-2:0], din}. Increment bit_cnt. After the WIDTH-th bit, go to PARITY.
- PARITY: latch par_ok = (^sh ^ din) == 0, then go to STOP.
- STOP (always returns to IDLE):
  - If din=1: pulse framing_err and discard the frame. framing_err takes priority; parity_err is not pulsed.
  - Else if !par_ok: pulse parity_err and discard the frame.
  - Else the frame is good:
    - If the output is free (dout_valid=0, or dout_valid & dout_ready this cycle): load dout_data <= sh, set dout_valid=1, increment frame_count.
    - Otherwise: pulse overrun, keep the old word and its dout_valid, and do not increment frame_count.
- Output handshake:
  - dout_valid clears on a rising edge where dout_valid & dout_ready and no new word loads.
  - When a consume and a load happen on the same edge, dout_valid stays 1 and dout_data takes the new word.
  - dout_ready is ignored while dout_valid=0.
- din is not inspected for a start bit during DATA, PARITY or STOP. A 1 in any of those positions is treated as data, parity or stop.

## Timing
- Reset values: dout_data=0, dout_valid=0, parity_err=0, framing_err=0, overrun=0, frame_count=0. State=IDLE; bit_cnt, sh and par_ok are cleared.
- Reset mid-frame discards the partial frame; the receiver is back in IDLE on the cycle after reset deasserts.
- Reset also clears a pending dout_valid; that word is lost.
- Latency: the start bit is sampled at edge k. Data bits are sampled at edges k+1..k+WIDTH, parity at k+WIDTH+1, and stop at k+WIDTH+2.
- dout_valid and the error pulses are registered and visible after edge k+WIDTH+2. For WIDTH=4 that is 6 edges after the start-bit edge, and 7 cycles per frame in total.
- Back-to-back frames: the next start bit may be sampled at edge k+WIDTH+3, the first IDLE cycle. This gives a sustained rate of one word per WIDTH+3 cycles.
- Error and overrun pulses are exactly 1 cycle wide and mutually exclusive per frame.
- frame_count wraps from 2^CNT_W−1 to 0 without any flag.

## Test plan
- Good frame (WIDTH=4), dout_ready=1: din sequence 1,1,0,1,1,1,0 → after the stop edge, dout_data=4'b1011, dout_valid=1 for 1 cycle, frame_count=1, no error pulses.
- Parity error: 1,1,0,1,1,0,0 → parity_err pulses for 1 cycle; dout_valid stays 0; frame_count is unchanged.
- Framing error: 1,0,1,1,0,1,1 (stop=1) → framing_err pulses and parity_err does not; the receiver is in IDLE next cycle, and a following valid frame 1,0,0,1,1,0,0 yields dout_data=4'b0011.
- Overrun: hold dout_ready=0 and send frames 1011 then 0110 back-to-back. The first is held (dout_data=4'b1011); on the second stop edge overrun pulses and frame_count=1. Raising dout_ready then clears dout_valid.
- Simultaneous consume and load: dout_valid=1 with 1011, dout_ready=1 on the stop edge of 0110 → dout_valid stays 1, dout_data=4'b0110, frame_count=2, no overrun.
- Reset mid-frame: assert rst for 1 cycle after 2 data bits → all outputs 0; the next full frame 1,1,1,1,1,0,0 gives dout_data=4'b1111.
